dma64_mem_responder: RTL and testbench
======================================

# dma64_mem_responder

- Memory-side responder for the 64-bit DMA protocol used by the accelerator wrappers.
- Accepts read and write control requests, streams 64-bit beats to and from an internal word-addressed memory, and reports status.
- Serves as on-chip scratchpad and as the synthesizable memory model in accelerator benches.
- Read and write engines run independently and concurrently.

## Interface
Parameters:
- ADDR_WIDTH, 10: memory depth is 2^ADDR_WIDTH 64-bit words.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- dma_read_ctrl_valid  in  1  read request valid.
- dma_read_ctrl_ready  out  1  read request accepted when high with valid.
- dma_read_ctrl_data_index  in  32  first word index.
- dma_read_ctrl_data_length  in  32  beat count.
- dma_read_ctrl_data_size  in  3  beat size; only 3'b011 (64-bit) is legal.
- dma_read_chnl_valid  out  1  read beat valid.
- dma_read_chnl_ready  in  1  initiator accepts beat.
- dma_read_chnl_data  out  64  read beat.
- dma_write_ctrl_valid / _ready / _data_index / _data_length / _data_size: same as the read control ports, for writes.
- dma_write_chnl_valid  in  1  write beat valid.
- dma_write_chnl_ready  out  1  responder accepts beat.
- dma_write_chnl_data  in  64  write beat.
- rd_busy  out  1  read engine not idle.
- wr_busy  out  1  write engine not idle.
- err  out  1  sticky error flag.
- rd_beats  out  32  read beats delivered since reset (wraps).
- wr_beats  out  32  write beats stored since reset (wraps).

## Operation
- Read FSM states: R_IDLE, R_FETCH, R_SEND.
  - R_IDLE: ctrl_ready=1. On handshake, latch addr=index[ADDR_WIDTH-1:0] and rem=length.
    - rem==0: stay in R_IDLE.
    - rem!=0: go to R_FETCH.
  - R_FETCH: issue a synchronous memory read at addr; go to R_SEND.
  - R_SEND: chnl_valid=1 with the registered data. On valid&ready: addr+1, rem-1, rd_beats+1. Next state is R_IDLE if rem was 1, else R_FETCH.
- Write FSM states: W_IDLE, W_DATA.
  - W_IDLE: ctrl_ready=1. On handshake, latch addr and rem the same way.
    - rem==0: stay in W_IDLE.
    - rem!=0: go to W_DATA.
  - W_DATA: chnl_ready=1. Each valid beat writes mem[addr] with chnl_data; addr+1, rem-1, wr_beats+1. The last beat returns to W_IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH: the address wraps at the top of memory, and index bits above ADDR_WIDTH are ignored.
- rem is a 32-bit down-counter.
- err is set on any of:
  - an accepted request with size != 3'b011 (the transfer still proceeds as 64-bit beats);
  - an accepted request with index[31:ADDR_WIDTH] != 0.
- err clears only on reset.
- Concurrent read and write requests in the same cycle are both accepted.
- Same-cycle read and write of the same address: the read returns the old data (read-before-write).
- Memory contents are not reset.

## Timing
- Reset values: every ready/valid output 0, except dma_read_ctrl_ready=1 and dma_write_ctrl_ready=1. dma_read_chnl_data=0, rd_busy=0, wr_busy=0, err=0, rd_beats=0, wr_beats=0. Both FSMs in their idle state.
- Control ready is a registered-state decode (ready = state==IDLE). It has no combinational path from any input.
- Read latency: ctrl handshake at cycle N gives chnl_valid at N+2. Sustained rate is 1 beat per 2 cycles with no backpressure.
- With chnl_valid high and chnl_ready low, chnl_data is held stable and valid stays high.
- Write throughput: 1 beat per cycle. A beat is stored in the cycle of its valid handshake. ctrl_ready returns high the cycle after the last beat.
- rd_busy = read state != R_IDLE. wr_busy = write state != W_IDLE.
- Reset asserted mid-transfer: both engines return to idle immediately. Partially written data stays in memory; no further beats are emitted or accepted.
- Write channel beats arriving while in W_IDLE are not accepted (chnl_ready=0).

## Structure
- Shared package dma64_pkg:
  - DMA_SIZE_64 = 3'b011;
  - read-state and write-state enums;
  - DMA beat width constant 64.
- Sub-module dma64_sdp_ram:
  - simple dual-port RAM, one synchronous read port and one write port;
  - parameter ADDR_WIDTH;
  - read-before-write behaviour.
- Top level holds the two FSMs, the address/remaining counters, the status logic and the output data register.

## Test plan
- Write request index=4, length=3, size=3'b011, beats A0/A1/A2 back-to-back -> writes complete in 3 cycles; then read index=4, length=3 -> returns A0, A1, A2; rd_beats=3, wr_beats=3, err=0.
- Read length=2 with chnl_ready low for 5 cycles on the first beat -> valid held, data stable, no beat lost or duplicated.
- Length=0 read and write requests -> accepted, ready high the next cycle, no channel activity, counters unchanged.
- ADDR_WIDTH=10, write index=1023, length=2 -> words 1023 and 0 written; read index=1023, length=2 returns both. Index=0x400 -> err=1, data lands at word 0.
- Simultaneous read and write to index 8 (length 1; memory preloaded with 0x11) with data 0x22 -> read returns 0x11 only when the RAM access is concurrent with the write; a later read returns 0x22. Size=3'b010 -> err=1.
- Reset asserted during the second of 4 write beats -> both readies high and chnl_ready low after reset; counters and err are 0.

Source files
------------

// File: rtl/dma64_pkg.sv
// Shared definitions for the 64-bit DMA memory responder: beat width,
// legal beat size encoding, engine state enums and request checking.
package dma64_pkg;

  localparam int         DMA_BEAT_W  = 64;
  localparam logic [2:0] DMA_SIZE_64 = 3'b011;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_SEND  = 2'd2
  } rd_state_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_DATA = 1'b1
  } wr_state_t;

  // A request is flagged when its size is not 64-bit or its index does
  // not fit in the memory; the transfer itself still proceeds.
  function automatic logic req_bad(input logic [31:0] index,
                                   input logic [2:0]  size,
                                   input int          aw);
    return (size != DMA_SIZE_64) || ((index >> aw) != 32'd0);
  endfunction

endpackage

// File: rtl/dma64_sdp_ram.sv
// Simple dual-port RAM: one synchronous read port, one write port.
// A read and a write to the same word in one cycle returns the old word.
// The array is not reset; only the read data register is.
module dma64_sdp_ram
  import dma64_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DMA_BEAT_W-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DMA_BEAT_W-1:0] wr_data
);

  logic [DMA_BEAT_W-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  // Write port: store one word per enabled cycle.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: registered output, held until the next enabled read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dma64_mem_responder.sv
// Memory-side responder for the 64-bit DMA protocol. Independent read
// and write engines stream beats to/from an internal scratchpad RAM.
//
// Handshake rule on every valid/ready pair: a transfer happens on the
// rising edge where both valid and ready are high. A valid source keeps
// valid and its payload stable until that edge. All ready/valid outputs
// here are decodes of registered state with no path from any input.
module dma64_mem_responder
  import dma64_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dma_read_ctrl_valid,
  output logic                  dma_read_ctrl_ready,
  input  logic [31:0]           dma_read_ctrl_data_index,
  input  logic [31:0]           dma_read_ctrl_data_length,
  input  logic [2:0]            dma_read_ctrl_data_size,
  output logic                  dma_read_chnl_valid,
  input  logic                  dma_read_chnl_ready,
  output logic [DMA_BEAT_W-1:0] dma_read_chnl_data,
  input  logic                  dma_write_ctrl_valid,
  output logic                  dma_write_ctrl_ready,
  input  logic [31:0]           dma_write_ctrl_data_index,
  input  logic [31:0]           dma_write_ctrl_data_length,
  input  logic [2:0]            dma_write_ctrl_data_size,
  input  logic                  dma_write_chnl_valid,
  output logic                  dma_write_chnl_ready,
  input  logic [DMA_BEAT_W-1:0] dma_write_chnl_data,
  output logic                  rd_busy,
  output logic                  wr_busy,
  output logic                  err,
  output logic [31:0]           rd_beats,
  output logic [31:0]           wr_beats
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  rd_state_t             rd_state;
  wr_state_t             wr_state;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           rd_rem;
  logic [31:0]           wr_rem;
  logic                  rd_req;
  logic                  wr_req;
  logic                  wr_beat;

  assign dma_read_ctrl_ready  = (rd_state == R_IDLE);
  assign dma_read_chnl_valid  = (rd_state == R_SEND);
  assign dma_write_ctrl_ready = (wr_state == W_IDLE);
  assign dma_write_chnl_ready = (wr_state == W_DATA);
  assign rd_busy              = (rd_state != R_IDLE);
  assign wr_busy              = (wr_state != W_IDLE);

  assign rd_req  = dma_read_ctrl_valid  && (rd_state == R_IDLE);
  assign wr_req  = dma_write_ctrl_valid && (wr_state == W_IDLE);
  assign wr_beat = dma_write_chnl_valid && (wr_state == W_DATA);

  // The RAM read register doubles as the read channel data register:
  // it only reloads in R_FETCH, so data holds steady under backpressure.
  dma64_sdp_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_state == R_FETCH),
    .rd_addr (rd_addr),
    .rd_data (dma_read_chnl_data),
    .wr_en   (wr_beat),
    .wr_addr (wr_addr),
    .wr_data (dma_write_chnl_data)
  );

  // Read engine: fetch a word, present it, advance on acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state <= R_IDLE;
      rd_addr  <= '0;
      rd_rem   <= '0;
      rd_beats <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (dma_read_ctrl_valid) begin
            rd_addr <= dma_read_ctrl_data_index[ADDR_WIDTH-1:0];
            rd_rem  <= dma_read_ctrl_data_length;
            if (dma_read_ctrl_data_length != 32'd0) rd_state <= R_FETCH;
          end
        end
        R_FETCH: rd_state <= R_SEND;
        R_SEND: begin
          if (dma_read_chnl_ready) begin
            rd_addr  <= rd_addr + ADDR_ONE;
            rd_rem   <= rd_rem - 32'd1;
            rd_beats <= rd_beats + 32'd1;
            rd_state <= (rd_rem == 32'd1) ? R_IDLE : R_FETCH;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // Write engine: accept one beat per cycle until the count runs out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state <= W_IDLE;
      wr_addr  <= '0;
      wr_rem   <= '0;
      wr_beats <= '0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (dma_write_ctrl_valid) begin
            wr_addr <= dma_write_ctrl_data_index[ADDR_WIDTH-1:0];
            wr_rem  <= dma_write_ctrl_data_length;
            if (dma_write_ctrl_data_length != 32'd0) wr_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (dma_write_chnl_valid) begin
            wr_addr  <= wr_addr + ADDR_ONE;
            wr_rem   <= wr_rem - 32'd1;
            wr_beats <= wr_beats + 32'd1;
            if (wr_rem == 32'd1) wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Sticky error: any accepted request with a bad size or oversized index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if ((rd_req && req_bad(dma_read_ctrl_data_index, dma_read_ctrl_data_size, ADDR_WIDTH)) ||
                 (wr_req && req_bad(dma_write_ctrl_data_index, dma_write_ctrl_data_size, ADDR_WIDTH))) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dma64_mem_responder.sv
// Self-checking bench for dma64_mem_responder: reset checks, a table of
// write/read-back transfers, directed multi-cycle corner cases, and a
// randomized phase against a word-array memory model.
module tb_dma64_mem_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dma_read_ctrl_valid = 1'b0;
  logic        dma_read_ctrl_ready;
  logic [31:0] dma_read_ctrl_data_index = '0;
  logic [31:0] dma_read_ctrl_data_length = '0;
  logic [2:0]  dma_read_ctrl_data_size = 3'b011;
  logic        dma_read_chnl_valid;
  logic        dma_read_chnl_ready = 1'b0;
  logic [63:0] dma_read_chnl_data;
  logic        dma_write_ctrl_valid = 1'b0;
  logic        dma_write_ctrl_ready;
  logic [31:0] dma_write_ctrl_data_index = '0;
  logic [31:0] dma_write_ctrl_data_length = '0;
  logic [2:0]  dma_write_ctrl_data_size = 3'b011;
  logic        dma_write_chnl_valid = 1'b0;
  logic        dma_write_chnl_ready;
  logic [63:0] dma_write_chnl_data = '0;
  logic        rd_busy;
  logic        wr_busy;
  logic        err;
  logic [31:0] rd_beats;
  logic [31:0] wr_beats;

  dma64_mem_responder #(.ADDR_WIDTH(10)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .dma_read_ctrl_valid        (dma_read_ctrl_valid),
    .dma_read_ctrl_ready        (dma_read_ctrl_ready),
    .dma_read_ctrl_data_index   (dma_read_ctrl_data_index),
    .dma_read_ctrl_data_length  (dma_read_ctrl_data_length),
    .dma_read_ctrl_data_size    (dma_read_ctrl_data_size),
    .dma_read_chnl_valid        (dma_read_chnl_valid),
    .dma_read_chnl_ready        (dma_read_chnl_ready),
    .dma_read_chnl_data         (dma_read_chnl_data),
    .dma_write_ctrl_valid       (dma_write_ctrl_valid),
    .dma_write_ctrl_ready       (dma_write_ctrl_ready),
    .dma_write_ctrl_data_index  (dma_write_ctrl_data_index),
    .dma_write_ctrl_data_length (dma_write_ctrl_data_length),
    .dma_write_ctrl_data_size   (dma_write_ctrl_data_size),
    .dma_write_chnl_valid       (dma_write_chnl_valid),
    .dma_write_chnl_ready       (dma_write_chnl_ready),
    .dma_write_chnl_data        (dma_write_chnl_data),
    .rd_busy                    (rd_busy),
    .wr_busy                    (wr_busy),
    .err                        (err),
    .rd_beats                   (rd_beats),
    .wr_beats                   (wr_beats)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [63:0] mem_model [DEPTH];
  bit          known     [DEPTH];
  int unsigned m_rd_beats = 0;
  int unsigned m_wr_beats = 0;
  bit          m_err = 1'b0;

  // Scoreboard of expected read beats; chk_q marks words with known content.
  logic [63:0] exp_q[$];
  bit          chk_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic bit req_err(input logic [31:0] idx, input logic [2:0] sz);
    return (sz != 3'b011) || (idx > 32'd1023);
  endfunction

  function automatic int unsigned word_of(input logic [31:0] idx, input int i);
    return (idx + i) % DEPTH;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_rd_beats"}, rd_beats, m_rd_beats);
    check({tag, "_wr_beats"}, wr_beats, m_wr_beats);
    check({tag, "_err"}, err, m_err);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rd_ctrl_ready"}, dma_read_ctrl_ready, 1);
    check({tag, "_wr_ctrl_ready"}, dma_write_ctrl_ready, 1);
    check({tag, "_rd_chnl_valid"}, dma_read_chnl_valid, 0);
    check({tag, "_wr_chnl_ready"}, dma_write_chnl_ready, 0);
    check({tag, "_rd_chnl_data"}, dma_read_chnl_data, 0);
    check({tag, "_rd_busy"}, rd_busy, 0);
    check({tag, "_wr_busy"}, wr_busy, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_rd_beats"}, rd_beats, 0);
    check({tag, "_wr_beats"}, wr_beats, 0);
  endtask

  task automatic do_reset();
    dma_read_ctrl_valid  = 1'b0;
    dma_write_ctrl_valid = 1'b0;
    dma_read_chnl_ready  = 1'b0;
    dma_write_chnl_valid = 1'b0;
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    m_rd_beats = 0;
    m_wr_beats = 0;
    m_err      = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic ctrl_wr(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] sz);
    int t = 0;
    dma_write_ctrl_valid       = 1'b1;
    dma_write_ctrl_data_index  = idx;
    dma_write_ctrl_data_length = len;
    dma_write_ctrl_data_size   = sz;
    while (!dma_write_ctrl_ready && t < 50) begin tick(); t++; end
    check("wr_ctrl_ready", dma_write_ctrl_ready, 1);
    tick();
    dma_write_ctrl_valid = 1'b0;
    if (req_err(idx, sz)) m_err = 1'b1;
  endtask

  task automatic wr_beat(input int unsigned word, input logic [63:0] d);
    int t = 0;
    dma_write_chnl_valid = 1'b1;
    dma_write_chnl_data  = d;
    while (!dma_write_chnl_ready && t < 50) begin tick(); t++; end
    check("wr_chnl_ready", dma_write_chnl_ready, 1);
    tick();
    dma_write_chnl_valid = 1'b0;
    mem_model[word] = d;
    known[word]     = 1'b1;
    m_wr_beats++;
  endtask

  task automatic ctrl_rd(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] sz);
    int t = 0;
    dma_read_ctrl_valid       = 1'b1;
    dma_read_ctrl_data_index  = idx;
    dma_read_ctrl_data_length = len;
    dma_read_ctrl_data_size   = sz;
    while (!dma_read_ctrl_ready && t < 50) begin tick(); t++; end
    check("rd_ctrl_ready", dma_read_ctrl_ready, 1);
    for (int i = 0; i < int'(len); i++) begin
      exp_q.push_back(mem_model[word_of(idx, i)]);
      chk_q.push_back(known[word_of(idx, i)]);
    end
    tick();
    dma_read_ctrl_valid = 1'b0;
    if (req_err(idx, sz)) m_err = 1'b1;
  endtask

  task automatic rd_beat(input int stall);
    int t = 0;
    logic [63:0] held;
    logic [63:0] e;
    bit k;
    dma_read_chnl_ready = 1'b0;
    while (!dma_read_chnl_valid && t < 20) begin tick(); t++; end
    check("rd_chnl_valid", dma_read_chnl_valid, 1);
    held = dma_read_chnl_data;
    for (int s = 0; s < stall; s++) begin
      tick();
      check("rd_hold_valid", dma_read_chnl_valid, 1);
      check("rd_hold_data", dma_read_chnl_data, held);
    end
    dma_read_chnl_ready = 1'b1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      k = chk_q.pop_front();
      if (k) check("rd_data", dma_read_chnl_data, e);
    end else begin
      check("rd_extra_beat", dma_read_chnl_valid, 0);
    end
    tick();
    dma_read_chnl_ready = 1'b0;
    m_rd_beats++;
  endtask

  task automatic do_write(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] sz);
    ctrl_wr(idx, len, sz);
    for (int i = 0; i < int'(len); i++) wr_beat(word_of(idx, i), {$urandom, $urandom});
    check("wr_done_busy", wr_busy, 0);
  endtask

  task automatic do_read(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] sz,
                         input int max_stall);
    ctrl_rd(idx, len, sz);
    for (int i = 0; i < int'(len); i++) rd_beat($urandom_range(0, max_stall));
    check("rd_done_busy", rd_busy, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          rst_first;
    logic [31:0] idx;
    logic [31:0] len;
    logic [2:0]  wsz;
    logic [2:0]  rsz;
    bit          exp_err;
  } vec_t;

  vec_t vecs[8];

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] a_data [3];

    vecs[0] = '{1'b0, 32'd12,    32'd3, 3'b011, 3'b011, 1'b0};
    vecs[1] = '{1'b0, 32'd1023,  32'd2, 3'b011, 3'b011, 1'b0};
    vecs[2] = '{1'b0, 32'd500,   32'd0, 3'b011, 3'b011, 1'b0};
    vecs[3] = '{1'b0, 32'd20,    32'd6, 3'b011, 3'b011, 1'b0};
    vecs[4] = '{1'b1, 32'h400,   32'd1, 3'b011, 3'b011, 1'b1};
    vecs[5] = '{1'b1, 32'd8,     32'd1, 3'b010, 3'b011, 1'b1};
    vecs[6] = '{1'b1, 32'd40,    32'd2, 3'b011, 3'b111, 1'b1};
    vecs[7] = '{1'b1, 32'd60,    32'd4, 3'b011, 3'b011, 1'b0};
    for (int i = 0; i < DEPTH; i++) begin mem_model[i] = '0; known[i] = 1'b0; end

    // Reset state
    rst = 1'b0;
    #12;
    check_reset_state("reset");
    tick();
    rst = 1'b1;
    tick();

    // Write A0..A2 back-to-back at index 4, read back with latency checks
    a_data[0] = 64'hA0A0_0000_0000_00A0;
    a_data[1] = 64'hA1A1_0000_0000_00A1;
    a_data[2] = 64'hA2A2_0000_0000_00A2;
    ctrl_wr(32'd4, 32'd3, 3'b011);
    check("a_wr_busy", wr_busy, 1);
    for (int i = 0; i < 3; i++) wr_beat(word_of(32'd4, i), a_data[i]);
    check("a_wr_ctrl_ready_after", dma_write_ctrl_ready, 1);
    check("a_wr_chnl_ready_after", dma_write_chnl_ready, 0);
    ctrl_rd(32'd4, 32'd3, 3'b011);
    check("a_rd_valid_n1", dma_read_chnl_valid, 0);
    tick();
    check("a_rd_valid_n2", dma_read_chnl_valid, 1);
    check("a_rd_data0", dma_read_chnl_data, 64'hA0A0_0000_0000_00A0);
    rd_beat(0);
    check("a_rd_gap", dma_read_chnl_valid, 0);
    rd_beat(0);
    rd_beat(0);
    check("a_rd_beats", rd_beats, 3);
    check("a_wr_beats", wr_beats, 3);
    check("a_err", err, 0);

    // Backpressure on the first of two beats
    ctrl_rd(32'd4, 32'd2, 3'b011);
    rd_beat(5);
    rd_beat(0);
    check("bp_queue_empty", exp_q.size(), 0);
    check_status("bp");

    // Zero-length requests
    ctrl_rd(32'd300, 32'd0, 3'b011);
    check("z_rd_ctrl_ready", dma_read_ctrl_ready, 1);
    check("z_rd_busy", rd_busy, 0);
    ctrl_wr(32'd300, 32'd0, 3'b011);
    check("z_wr_ctrl_ready", dma_write_ctrl_ready, 1);
    check("z_wr_chnl_ready", dma_write_chnl_ready, 0);
    repeat (3) begin
      tick();
      check("z_rd_valid_idle", dma_read_chnl_valid, 0);
    end
    check_status("zero");

    // Table-driven write / read-back vectors
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].rst_first) do_reset();
      do_write(vecs[v].idx, vecs[v].len, vecs[v].wsz);
      do_read(vecs[v].idx, vecs[v].len, vecs[v].rsz, 2);
      check($sformatf("vec%0d_err", v), err, vecs[v].exp_err);
      check_status($sformatf("vec%0d", v));
    end
    // Oversized index 0x400 above landed at word 0
    ctrl_rd(32'd0, 32'd1, 3'b011);
    rd_beat(0);

    // Same-cycle read and write of word 8: read sees the old value
    do_reset();
    ctrl_wr(32'd8, 32'd1, 3'b011);
    wr_beat(8, 64'h11);
    dma_read_ctrl_valid        = 1'b1;
    dma_read_ctrl_data_index   = 32'd8;
    dma_read_ctrl_data_length  = 32'd1;
    dma_read_ctrl_data_size    = 3'b011;
    dma_write_ctrl_valid       = 1'b1;
    dma_write_ctrl_data_index  = 32'd8;
    dma_write_ctrl_data_length = 32'd1;
    dma_write_ctrl_data_size   = 3'b011;
    tick();
    dma_read_ctrl_valid  = 1'b0;
    dma_write_ctrl_valid = 1'b0;
    check("rw_both_busy", {rd_busy, wr_busy}, 2'b11);
    dma_write_chnl_valid = 1'b1;
    dma_write_chnl_data  = 64'h22;
    tick();
    dma_write_chnl_valid = 1'b0;
    check("rw_valid", dma_read_chnl_valid, 1);
    check("rw_old_data", dma_read_chnl_data, 64'h11);
    dma_read_chnl_ready = 1'b1;
    tick();
    dma_read_chnl_ready = 1'b0;
    mem_model[8] = 64'h22;
    m_wr_beats++;
    m_rd_beats++;
    check_status("rw");
    ctrl_rd(32'd8, 32'd1, 3'b011);
    rd_beat(0);
    ctrl_rd(32'd8, 32'd1, 3'b010);
    rd_beat(0);
    check("size010_err", err, 1);

    // Reset asserted during the second of four write beats
    ctrl_wr(32'd201, 32'd1, 3'b011);
    wr_beat(201, 64'h55);
    ctrl_wr(32'd200, 32'd4, 3'b011);
    wr_beat(200, 64'hB0);
    dma_write_chnl_valid = 1'b1;
    dma_write_chnl_data  = 64'hB1;
    #2;
    rst = 1'b0;
    #2;
    check_reset_state("midrst_in");
    dma_write_chnl_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check_reset_state("midrst_out");
    m_rd_beats = 0;
    m_wr_beats = 0;
    m_err      = 1'b0;
    ctrl_rd(32'd200, 32'd2, 3'b011);
    rd_beat(0);
    rd_beat(1);
    check_status("midrst");

    // Randomized transfers against the model
    for (int r = 0; r < 40; r++) begin
      logic [31:0] idx;
      logic [31:0] len;
      logic [2:0]  sz;
      idx = $urandom_range(0, 1100);
      len = $urandom_range(0, 5);
      sz  = ($urandom_range(0, 7) == 0) ? 3'b010 : 3'b011;
      if ($urandom_range(0, 1) == 0) do_write(idx, len, sz);
      else do_read(idx, len, sz, 3);
      check_status($sformatf("rand%0d", r));
    end
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
